io_input_conditioner: RTL and testbench
=======================================

// Module: io_input_conditioner
// PURPOSE
//  Input-side counterpart of the HEX display path: conditions the board SW[17:0]
//  and KEY[3:0] inputs and presents them to the CPU. The CPU reads SW as io0_data.
//  Key presses become sticky events that the CPU acknowledges.
//  Sits between the top-level pins and the CPU io0 input port; all logic is in
//  the CPU clock domain.
// PARAMETERS
//  SW_W          18      switch vector width; io0_data zero-pads above it
//  KEY_W         4       key count; raw keys are active-low
//  DEBOUNCE_CYC  500000  cycles of stable input before accept (10 ms at 50 MHz)
// PORTS
//  clk        in   1      CPU clock
//  rst        in   1      async, active-high reset
//  sw_raw     in   SW_W   unsynchronised switch levels
//  key_raw    in   KEY_W  unsynchronised keys, 0 = pressed
//  io0_data   out  32     {(32-SW_W)'b0, sw_db}; CPU io0 read value
//  key_level  out  KEY_W  debounced key state, 1 = pressed
//  key_evt    out  KEY_W  sticky press-event flags
//  evt_clr    in   KEY_W  write-1-to-clear for key_evt, single-cycle pulse
//  sw_chg     out  1      1-cycle pulse when sw_db takes a new value
// BEHAVIOUR
//  - Reset values:
//    - sync stages and sw_db: 0; io0_data = 0.
//    - key sync and key_db: 1 (released), so key_level = 0.
//    - key_evt, sw_chg and all counters: 0.
//  - Sync: 2-FF synchroniser per bit. A raw change reaches the sync output 2 cycles later.
//  - Debounce (SW bus, handled as one channel; each key is its own channel):
//    - Each channel holds a candidate cand, a counter cnt and a debounced value db.
//    - If sync != cand: cand <= sync, cnt <= 0.
//    - Else if cand != db: cnt++. When cnt == DEBOUNCE_CYC-1: db <= cand, cnt <= 0.
//    - Else (cand == db): cnt holds at 0.
//  - Latency: a clean raw edge updates db exactly 2+DEBOUNCE_CYC+1 cycles after
//    the raw change. Any glitch shorter than DEBOUNCE_CYC restarts the count; db never changes.
//  - SW value switches A->B->C mid-count: the count restarts on B and on C; only C is ever accepted.
//  - sw_chg: asserted in the cycle after sw_db changes, for exactly 1 cycle.
//  - key_evt[i]:
//    - Set on a key_db[i] 1->0 transition, i.e. a debounced press.
//    - Cleared by evt_clr[i].
//    - Set and clear in the same cycle: set wins, so no press is lost.
//    - Release edges never set an event.
//  - Counter width: $clog2(DEBOUNCE_CYC); cnt saturates by construction, no wrap.
//  - Reset mid-count or mid-event: everything returns to reset values immediately (async).
//    After reset deasserts, a held key produces no event until it is released and pressed again.
// CONFIGURATION
//  IO_IN_IRQ_EN defined:
//    - Adds port irq (out, 1).
//    - irq is registered OR of (key_evt & irq_mask), where irq_mask (in, KEY_W) is a new port.
//    - irq resets to 0 and deasserts the cycle after the last masked event is cleared.
//  IO_IN_IRQ_EN undefined: no irq or irq_mask ports; all other behaviour is identical.
// STRUCTURE
//  Package io_in_pkg:
//    - constants IO_W=32, SW_W_DEF=18, KEY_W_DEF=4, DEBOUNCE_CYC_DEF.
//    - typedef io_word_t = logic [IO_W-1:0].
//  Sub-module debounce_cell #(W, CYCLES, RST_VAL):
//    - contains sync + cand/cnt/db.
//    - instanced once for SW (W=SW_W, RST_VAL=0) and KEY_W times for keys (W=1, RST_VAL=1).
//  Top of this block holds edge detect, event flags, sw_chg, optional irq.
// TESTING  (bench uses DEBOUNCE_CYC=4)
//  1. Reset, then sw_raw=18'd12345 held:
//     -> io0_data=32'h00003039 at cycle 7 after the change; sw_chg pulses once.
//  2. key_raw[1] low for 3 cycles, then high:
//     -> key_level, key_evt unchanged (glitch rejected).
//  3. key_raw[2] low, held:
//     -> key_level[2]=1 and key_evt=4'b0100 at cycle 7; pulse evt_clr=4'b0100
//     -> key_evt=0 next cycle.
//  4. Second key_raw[2] press debounces in the same cycle as evt_clr[2]=1:
//     -> key_evt[2] stays 1.
//  5. sw_raw 0->5->9 with 2 cycles between steps:
//     -> io0_data goes 0->9 directly, never 5; one sw_chg pulse.
//  6. rst asserted mid-count with key held:
//     -> all outputs reset at once; after release, no event until the key is released and re-pressed.
//     With IO_IN_IRQ_EN, irq_mask=4'b0100: irq=1 one cycle after key_evt[2] sets.

Source files
------------

// File: rtl/io_in_pkg.sv
// io_in_pkg: shared constants and types for the io0 input conditioner.
// Revision: 1.0
`default_nettype none

package io_in_pkg;
  localparam int IO_W             = 32;
  localparam int SW_W_DEF         = 18;
  localparam int KEY_W_DEF        = 4;
  localparam int DEBOUNCE_CYC_DEF = 500000;

  typedef logic [IO_W-1:0] io_word_t;
endpackage

`default_nettype wire

// File: rtl/io_input_conditioner_debounce_cell.sv
// debounce_cell: 2-FF synchroniser followed by a candidate/counter debouncer.
// Revision: 1.0
`default_nettype none

module debounce_cell
  import io_in_pkg::*;
#(
  parameter int             W       = 1,
  parameter int             CYCLES  = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_db,
  output logic         o_acc
);

  localparam int             c_cnt_w = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam [c_cnt_w-1:0]   c_last  = c_cnt_w'(CYCLES - 1);

  logic [W-1:0]       r_s1;
  logic [W-1:0]       r_s2;
  logic [W-1:0]       r_cand;
  logic [W-1:0]       r_db;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_cand <= RST_VAL;
      r_db   <= RST_VAL;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cand != r_db) begin
        if (r_cnt == c_last) begin
          r_db  <= r_cand;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // High in the cycle whose closing edge loads cand into db.
  assign o_acc  = (r_s2 == r_cand) && (r_cand != r_db) && (r_cnt == c_last);
  assign o_sync = r_s2;
  assign o_db   = r_db;

endmodule

`default_nettype wire

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: debounced SW/KEY inputs, sticky key events, io0 read word.
// Optional interrupt output enabled by defining IO_IN_IRQ_EN. Revision: 1.0
`default_nettype none

module io_input_conditioner
  import io_in_pkg::*;
#(
  parameter int SW_W         = SW_W_DEF,
  parameter int KEY_W        = KEY_W_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [KEY_W-1:0] key_raw,
  output io_word_t         io0_data,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_evt,
  input  logic [KEY_W-1:0] evt_clr,
  output logic             sw_chg
`ifdef IO_IN_IRQ_EN
  ,
  input  logic [KEY_W-1:0] irq_mask,
  output logic             irq
`endif
);

  logic [SW_W-1:0]  w_sw_db;
  logic [SW_W-1:0]  w_sw_sync;
  logic             w_sw_acc;
  logic [KEY_W-1:0] w_key_db;
  logic [KEY_W-1:0] w_key_sync;
  logic [KEY_W-1:0] w_key_acc;
  logic [KEY_W-1:0] w_press;

  logic [SW_W-1:0]  r_sw_prev;
  logic             r_sw_chg;
  logic [KEY_W-1:0] r_key_evt;
  logic [KEY_W-1:0] r_arm;
  logic [1:0]       r_vld;

  debounce_cell #(
    .W       (SW_W),
    .CYCLES  (DEBOUNCE_CYC),
    .RST_VAL ({SW_W{1'b0}})
  ) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .i_d    (sw_raw),
    .o_sync (w_sw_sync),
    .o_db   (w_sw_db),
    .o_acc  (w_sw_acc)
  );

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    debounce_cell #(
      .W       (1),
      .CYCLES  (DEBOUNCE_CYC),
      .RST_VAL (1'b1)
    ) u_key_db (
      .clk    (clk),
      .rst    (rst),
      .i_d    (key_raw[i]),
      .o_sync (w_key_sync[i]),
      .o_db   (w_key_db[i]),
      .o_acc  (w_key_acc[i])
    );
  end

  // A press is accepted only while db still reads released and the key has
  // been seen released since reset, so a key held through reset stays silent.
  assign w_press = w_key_acc & w_key_db & r_arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_prev <= '0;
      r_sw_chg  <= 1'b0;
      r_key_evt <= '0;
      r_arm     <= '0;
      r_vld     <= 2'b00;
    end else begin
      r_sw_prev <= w_sw_db;
      r_sw_chg  <= (w_sw_db != r_sw_prev);
      r_key_evt <= (r_key_evt & ~evt_clr) | w_press;
      r_vld     <= {r_vld[0], 1'b1};
      r_arm     <= r_arm | ({KEY_W{r_vld[1]}} & w_key_sync);
    end
  end

`ifdef IO_IN_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |(r_key_evt & irq_mask);
  end

  assign irq = r_irq;
`endif

  assign io0_data  = io_word_t'(w_sw_db);
  assign key_level = ~w_key_db;
  assign key_evt   = r_key_evt;
  assign sw_chg    = r_sw_chg;

  // Raw sync and accept strobe of the switch bus are not needed at this level.
  logic w_unused;
  assign w_unused = ^{w_sw_sync, w_sw_acc};

endmodule

`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: scoreboard bench with directed vectors, DEBOUNCE_CYC=4.
// Revision: 1.0
`default_nettype none

module tb_io_input_conditioner;

  logic        clk;
  logic        rst;
  logic [17:0] sw_raw;
  logic [3:0]  key_raw;
  logic [31:0] io0_data;
  logic [3:0]  key_level;
  logic [3:0]  key_evt;
  logic [3:0]  evt_clr;
  logic        sw_chg;
`ifdef IO_IN_IRQ_EN
  logic [3:0]  irq_mask;
  logic        irq;
`endif

  io_input_conditioner #(
    .SW_W         (18),
    .KEY_W        (4),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .key_raw   (key_raw),
    .io0_data  (io0_data),
    .key_level (key_level),
    .key_evt   (key_evt),
    .evt_clr   (evt_clr),
    .sw_chg    (sw_chg)
`ifdef IO_IN_IRQ_EN
    ,
    .irq_mask  (irq_mask),
    .irq       (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          kind;   // 0 io0_data, 1 key_level, 2 key_evt, 3 sw_chg, 4 irq
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push(input int at, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    int   p;
    e.at = at; e.kind = kind; e.val = val; e.name = name;
    p = q.size();
    while (p > 0 && q[p-1].at > at) p--;
    q.insert(p, e);
  endtask

  // Advance to 2 time units after the posedge that makes cyc == n.
  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  // Monitor: samples outputs on the falling edge, away from stimulus and clock.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = io0_data;
        1:       act = {28'b0, key_level};
        2:       act = {28'b0, key_evt};
        3:       act = {31'b0, sw_chg};
`ifdef IO_IN_IRQ_EN
        4:       act = {31'b0, irq};
`endif
        default: act = 32'hDEAD_BEEF;
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %h expected %h", e.name, cyc, act, e.val);
      end
    end
  end

  int t;
  int t2;

  initial begin
    rst     = 1'b1;
    sw_raw  = '0;
    key_raw = 4'hF;
    evt_clr = 4'h0;
`ifdef IO_IN_IRQ_EN
    irq_mask = 4'b0100;
`endif
    push(1, 0, 32'h0, "rst_io0");
    push(1, 1, 32'h0, "rst_key_level");
    push(1, 2, 32'h0, "rst_key_evt");
    push(1, 3, 32'h0, "rst_sw_chg");
`ifdef IO_IN_IRQ_EN
    push(1, 4, 32'h0, "rst_irq");
`endif
    at_cyc(3);
    rst = 1'b0;

    // 1: clean switch change
    at_cyc(12);
    t = cyc;
    sw_raw = 18'd12345;
    for (int k = 0; k < 7; k++) push(t + k, 0, 32'h0, "sw_hold_old");
    push(t + 7, 0, 32'h0000_3039, "sw_accept");
    for (int k = 0; k < 8; k++) push(t + k, 3, 32'h0, "sw_chg_idle");
    push(t + 8, 3, 32'h1, "sw_chg_pulse");
    push(t + 9, 3, 32'h0, "sw_chg_end");

    // 2: 3-cycle glitch on key 1
    at_cyc(t + 12);
    t = cyc;
    key_raw = 4'b1101;
    push(t + 7,  1, 32'h0, "glitch_level");
    push(t + 10, 1, 32'h0, "glitch_level_late");
    push(t + 10, 2, 32'h0, "glitch_evt");
    at_cyc(t + 3);
    key_raw = 4'b1111;

    // 3: clean press on key 2, then acknowledge
    at_cyc(t + 12);
    t = cyc;
    key_raw = 4'b1011;
    push(t + 6, 1, 32'h0, "press_level_early");
    push(t + 7, 1, 32'h4, "press_level");
    push(t + 6, 2, 32'h0, "press_evt_early");
    push(t + 7, 2, 32'h4, "press_evt");
    push(t + 8, 2, 32'h4, "press_evt_sticky");
`ifdef IO_IN_IRQ_EN
    push(t + 7,  4, 32'h0, "irq_early");
    push(t + 8,  4, 32'h1, "irq_set");
    push(t + 10, 4, 32'h0, "irq_clear");
`endif
    at_cyc(t + 8);
    evt_clr = 4'b0100;
    push(t + 9, 2, 32'h0, "evt_cleared");
    at_cyc(t + 9);
    evt_clr = 4'b0000;

    // 4: release (no event), then press debounced in the same cycle as clear
    at_cyc(t + 12);
    t = cyc;
    key_raw = 4'b1111;
    push(t + 7, 1, 32'h0, "release_level");
    push(t + 8, 2, 32'h0, "release_no_evt");
    at_cyc(t + 10);
    t2 = cyc;
    key_raw = 4'b1011;
    push(t2 + 6, 2, 32'h0, "setclr_before");
    push(t2 + 7, 2, 32'h4, "setclr_set_wins");
    push(t2 + 8, 2, 32'h4, "setclr_held");
`ifdef IO_IN_IRQ_EN
    push(t2 + 8, 4, 32'h1, "irq_setclr");
`endif
    at_cyc(t2 + 6);
    evt_clr = 4'b0100;
    at_cyc(t2 + 7);
    evt_clr = 4'b0000;
    at_cyc(t2 + 9);
    evt_clr = 4'b0100;
    push(t2 + 10, 2, 32'h0, "setclr_cleared");
    at_cyc(t2 + 10);
    evt_clr = 4'b0000;
    key_raw = 4'b1111;

    // 5: switch value A->B->C mid-count
    at_cyc(t2 + 20);
    t = cyc;
    sw_raw = 18'd0;
    push(t + 8, 0, 32'h0, "sw_back_to_zero");
    at_cyc(t + 10);
    t2 = cyc;
    sw_raw = 18'd5;
    for (int k = 0; k < 9; k++) push(t2 + k, 0, 32'h0, "sw_no_intermediate");
    push(t2 + 9, 0, 32'h9, "sw_final_value");
    for (int k = 0; k < 10; k++) push(t2 + k, 3, 32'h0, "sw_chg_quiet");
    push(t2 + 10, 3, 32'h1, "sw_chg_once");
    push(t2 + 11, 3, 32'h0, "sw_chg_once_end");
    at_cyc(t2 + 2);
    sw_raw = 18'd9;

    // 6: reset mid-count with key 2 held
    at_cyc(t2 + 14);
    t = cyc;
    key_raw = 4'b1011;
    at_cyc(t + 4);
    rst = 1'b1;
    push(t + 4, 0, 32'h0, "midrst_io0");
    push(t + 4, 1, 32'h0, "midrst_level");
    push(t + 4, 2, 32'h0, "midrst_evt");
    push(t + 5, 3, 32'h0, "midrst_sw_chg");
    push(t + 12, 1, 32'h0, "held_level_early");
    push(t + 13, 1, 32'h4, "held_level");
    push(t + 13, 2, 32'h0, "held_no_evt");
    push(t + 16, 2, 32'h0, "held_no_evt_late");
    at_cyc(t + 6);
    rst = 1'b0;
    at_cyc(t + 17);
    t = cyc;
    key_raw = 4'b1111;
    push(t + 7, 1, 32'h0, "rearm_release");
    push(t + 8, 2, 32'h0, "rearm_release_no_evt");
    at_cyc(t + 10);
    t = cyc;
    key_raw = 4'b1011;
    push(t + 6, 2, 32'h0, "repress_early");
    push(t + 7, 2, 32'h4, "repress_evt");
`ifdef IO_IN_IRQ_EN
    push(t + 8, 4, 32'h1, "repress_irq");
`endif
    at_cyc(t + 10);

    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
